// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter feeding a single APB master sequencer (IDLE/SETUP/ACCESS/RESP).
// One transfer in flight at a time; an ACCESS-phase timeout turns a hung slave into an error response.
module apb_rr_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0]                  req_write_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                                rsp_err_o,
    output logic                                timeout_o,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [APB_ADDR_WIDTH-1:0]           PADDR,
    output logic [APB_DATA_WIDTH-1:0]           PWDATA,
    input  logic [APB_DATA_WIDTH-1:0]           PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR,
    output logic [1:0]                          dbg_state_o
);

    // Handshake: req_ready_o[i] pulses in the IDLE cycle that accepts requester i's stable
    // request; rsp_valid_o[i] is a one-cycle pulse with no backpressure.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TO_VAL  = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          rr_q, rr_d;
    logic [IDX_W-1:0]          gnt_q, gnt_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      timeout_q, timeout_d;

    logic                      gnt_found;
    logic [IDX_W-1:0]          gnt_idx;
    logic [IDX_W-1:0]          cand;
    logic [CNT_W:0]            cnt_inc;
    logic                      timeout_hit;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDX_W-1:0];
    endfunction

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(rr_q, k);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timeout_d   = 1'b0;
        req_ready_o = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found && !ARESET) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    gnt_d   = gnt_idx;
                    write_d = req_write_i[gnt_idx];
                    addr_d  = req_addr_i[int'(gnt_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d = req_write_i[gnt_idx] ?
                              req_wdata_i[int'(gnt_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH] : '0;
                    rr_d    = wrap_idx(gnt_idx, 1);
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                // PREADY takes precedence over a coincident timeout.
                if (PREADY) begin
                    rdata_d = write_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == S_RESP) rsp_valid_o[gnt_q] = 1'b1;
    end

    // Address/data are driven straight from the latch so they hold between transfers.
    assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign PWRITE      = write_q;
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Directed bench for apb_rr_master_arbiter: bench-side APB slave model plus a response scoreboard.
module tb_apb_rr_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int EW = N + DW + 2;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [N-1:0]    req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [DW-1:0]   rsp_rdata_o, PWDATA, PRDATA;
  logic [AW-1:0]   PADDR;
  logic            rsp_err_o, timeout_o, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [1:0]      dbg_state_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];

  // slave model controls
  logic          slave_hang;
  int            slave_wait;
  logic [DW-1:0] slave_rdata;
  logic          slave_err;
  int            acc_cnt = 0;

  apb_rr_master_arbiter #(
    .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .timeout_o(timeout_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // slave: answers after slave_wait wait-state ACCESS cycles unless hung
  always @(posedge ACLK) acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
  assign PREADY  = PSEL && PENABLE && !slave_hang && (acc_cnt >= slave_wait);
  assign PRDATA  = slave_rdata ^ PADDR;
  assign PSLVERR = PREADY && slave_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input int idx, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    req_valid_i[idx] = 1'b1;
    req_write_i[idx] = wr;
    req_addr_i[idx*AW +: AW] = addr;
    req_wdata_i[idx*DW +: DW] = wdata;
  endtask

  task automatic drop_req(input int idx);
    req_valid_i[idx] = 1'b0;
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] rd, input logic err, input logic to);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({oh, rd, err, to});
  endtask

  task automatic wait_ready(input int idx);
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready_o[idx]) return;
      @(negedge ACLK);
    end
    check("wait_ready_bound", req_ready_o[idx], 1);
  endtask

  task automatic count_access(input string tag, input int bound, output int n_acc);
    n_acc = 0;
    for (int k = 0; k < bound; k++) begin
      #1;
      if (PSEL && PENABLE) n_acc++;
      if (rsp_valid_o != '0) return;
      check({tag, "_no_early_timeout"}, timeout_o, 0);
      @(negedge ACLK);
    end
    check({tag, "_rsp_bound"}, rsp_valid_o != '0, 1);
  endtask

  // scoreboard: every response pulse pops one expected entry
  always @(negedge ACLK) begin
    if (ARESET === 1'b0 && rsp_valid_o !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid_o, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp", {rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o}, e);
      end
    end
  end

  initial begin
    int rr_ord[6];
    logic [N-1:0] g_oh[$];
    int g_cyc[$];
    int n_acc;
    logic [N-1:0] oh;

    rr_ord = '{0, 1, 3, 0, 1, 3};
    ARESET = 1'b1;
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    slave_hang = 1'b0; slave_wait = 0; slave_rdata = '0; slave_err = 1'b0;

    repeat (3) @(negedge ACLK);
    #1;
    check("rst_ctrl", {PSEL, PENABLE, PWRITE}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_hs", {req_ready_o, rsp_valid_o, rsp_err_o, timeout_o}, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // single read, no wait states
    @(negedge ACLK);
    slave_rdata = 32'hDEADBEEF ^ 32'h1000_0040;
    drive_req(2, 1'b0, 32'h1000_0040, 32'hFFFF_FFFF);
    #1 check("t1_ready", req_ready_o, 4'b0100);
    push_exp(2, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge ACLK); drop_req(2);
    #1 check("t1_setup", {PSEL, PENABLE}, 2'b10);
    check("t1_paddr", PADDR, 32'h1000_0040);
    check("t1_pwrite_pwdata", {PWRITE, PWDATA}, 0);
    @(negedge ACLK);
    #1 check("t1_access", {PSEL, PENABLE}, 2'b11);
    @(negedge ACLK);
    #1 check("t1_resp", {PSEL, PENABLE, rsp_valid_o}, {2'b00, 4'b0100});

    // round robin with requesters 0,1,3 continuously valid
    do_reset();
    slave_rdata = 32'h1234_5678;
    for (int i = 0; i < N; i++)
      if (i != 2) drive_req(i, 1'b0, 32'h4000_0000 + 32'(i * 16), '0);
    for (int k = 0; k < 6; k++)
      push_exp(rr_ord[k], 32'h1234_5678 ^ (32'h4000_0000 + 32'(rr_ord[k] * 16)), 1'b0, 1'b0);
    for (int k = 0; k < 60 && g_oh.size() < 6; k++) begin
      #1;
      if (req_ready_o != '0) begin
        g_oh.push_back(req_ready_o);
        g_cyc.push_back(cyc);
      end
      @(negedge ACLK);
    end
    req_valid_i = '0;
    check("t2_grant_count", g_oh.size(), 6);
    for (int k = 0; k < g_oh.size(); k++) begin
      oh = '0;
      oh[rr_ord[k]] = 1'b1;
      check($sformatf("t2_grant%0d", k), g_oh[k], oh);
      if (k > 0) check($sformatf("t2_gap%0d", k), g_cyc[k] - g_cyc[k-1], 4);
    end
    repeat (4) @(negedge ACLK);

    // write with wait states and slave error
    slave_wait = 3; slave_err = 1'b1;
    drive_req(1, 1'b1, 32'h20, 32'hA5A5A5A5);
    #1 check("t3_ready", req_ready_o, 4'b0010);
    push_exp(1, 32'h0, 1'b1, 1'b0);
    @(negedge ACLK); drop_req(1);
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (PSEL) check("t3_pwdata", {PWRITE, PWDATA}, {1'b1, 32'hA5A5A5A5});
      if (PSEL && PENABLE) n_acc++;
      check("t3_no_timeout", timeout_o, 0);
      if (rsp_valid_o != '0) break;
      @(negedge ACLK);
    end
    check("t3_access_cycles", n_acc, 4);
    check("t3_paddr_hold", PADDR, 32'h20);
    slave_err = 1'b0;
    @(negedge ACLK);

    // timeout with req 2 pending behind it
    slave_hang = 1'b1;
    drive_req(0, 1'b0, 32'h30, '0);
    #1 check("t4_ready", req_ready_o, 4'b0001);
    push_exp(0, 32'h0, 1'b1, 1'b1);
    @(negedge ACLK); drop_req(0);
    drive_req(2, 1'b0, 32'h50, '0);
    slave_rdata = 32'hCAFE_0000;
    count_access("t4", 30, n_acc);
    check("t4_access_cycles", n_acc, 8);
    check("t4_resp", {PSEL, PENABLE, timeout_o, rsp_err_o}, 4'b0011);
    check("t4_no_arb_in_resp", req_ready_o, 0);
    slave_hang = 1'b0; slave_wait = 7;
    @(negedge ACLK);
    #1 check("t4_next_grant", req_ready_o, 4'b0100);
    check("t4_timeout_pulse_end", timeout_o, 0);
    push_exp(2, 32'hCAFE_0000 ^ 32'h50, 1'b0, 1'b0);
    @(negedge ACLK); drop_req(2);

    // boundary: PREADY on the 8th ACCESS cycle completes normally
    count_access("t5", 30, n_acc);
    check("t5_access_cycles", n_acc, 8);
    check("t5_resp", {timeout_o, rsp_err_o, rsp_rdata_o}, {2'b00, 32'hCAFE_0050});
    slave_wait = 0;
    @(negedge ACLK);

    // reset while PENABLE=1
    slave_hang = 1'b1;
    drive_req(3, 1'b0, 32'h70, '0);
    #1 check("t6_ready", req_ready_o, 4'b1000);
    @(negedge ACLK); drop_req(3);
    @(negedge ACLK);
    #1 check("t6_in_access", PENABLE, 1);
    ARESET = 1'b1;
    drive_req(0, 1'b0, 32'h80, '0);
    drive_req(3, 1'b0, 32'h70, '0);
    @(negedge ACLK);
    #1 check("t6_rst_ctrl", {PSEL, PENABLE, PWRITE, req_ready_o, rsp_valid_o, rsp_err_o, timeout_o}, 0);
    check("t6_rst_bus", {PADDR, PWDATA}, 0);
    check("t6_rst_rdata", rsp_rdata_o, 0);
    ARESET = 1'b0;
    slave_hang = 1'b0; slave_rdata = 32'h0BAD_F00D;
    #1 check("t6_prio0", req_ready_o, 4'b0001);
    push_exp(0, 32'h0BAD_F00D ^ 32'h80, 1'b0, 1'b0);
    @(negedge ACLK); drop_req(0);
    wait_ready(3);
    check("t6_then3", req_ready_o, 4'b1000);
    push_exp(3, 32'h0BAD_F00D ^ 32'h70, 1'b0, 1'b0);
    @(negedge ACLK); drop_req(3);
    repeat (6) @(negedge ACLK);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
